// File: rtl/fta_arbiter32.sv
// Round-robin arbiter sharing one registered 32-bit FTA slave port among NREQ requesters.
// The response is steered back combinationally; a watchdog forces err on a silent slave.
package fta_arbiter32_pkg;

   typedef struct packed {
      logic        cyc;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
      logic [5:0]  blen;
      logic [3:0]  pri;
   } fta_cmd_request32_t;

   typedef struct packed {
      logic        ack;
      logic        err;
      logic        rty;
      logic        next;
      logic        stall;
      logic [31:0] dat;
   } fta_cmd_response32_t;

endpackage

module fta_arbiter32
   import fta_arbiter32_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                rst_i,
   input  logic                clk_i,
   input  fta_cmd_request32_t  req_i  [NREQ],
   output fta_cmd_response32_t resp_o [NREQ],
   output fta_cmd_request32_t  req_o,
   input  fta_cmd_response32_t resp_i,
   output logic [NREQ-1:0]     gnt_o,
   output logic                tmo_o
);

   localparam int OW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT_REL
   } state_t;

   state_t             state_q, state_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [9:0]         wd_cnt_q, wd_cnt_d;
   fta_cmd_request32_t req_q, req_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;

   logic               found;
   logic [OW-1:0]      win;
   logic [OW-1:0]      cand;
   logic [OW-1:0]      next_ptr;
   logic               owner_cyc;
   logic               slave_resp;
   logic               fire;

   // First requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = OW'((32'(rr_ptr_q) + i) % NREQ);
         if (!found && req_i[cand].cyc) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      owner_cyc  = req_i[owner_q].cyc;
      next_ptr   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      slave_resp = resp_i.ack | resp_i.err | resp_i.rty;
      // A release in the expiry cycle wins over the watchdog.
      fire       = (state_q == GRANT) && owner_cyc && !slave_resp &&
                   (wd_cnt_q == 10'(TIMEOUT));
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      wd_cnt_d = wd_cnt_q;
      req_d    = '0;
      gnt_d    = gnt_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               state_d    = GRANT;
               owner_d    = win;
               req_d      = req_i[win];
               gnt_d[win] = 1'b1;
               wd_cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!owner_cyc) begin
               state_d  = IDLE;
               gnt_d    = '0;
               rr_ptr_d = next_ptr;
               wd_cnt_d = '0;
            end else if (fire) begin
               state_d  = WAIT_REL;
               wd_cnt_d = '0;
            end else begin
               req_d    = req_i[owner_q];
               wd_cnt_d = slave_resp ? '0 : wd_cnt_q + 10'd1;
            end
         end
         WAIT_REL: begin
            if (!owner_cyc) begin
               state_d  = IDLE;
               gnt_d    = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Waiting requesters see stall; only the owner in GRANT sees the slave.
   always_comb begin
      for (int unsigned n = 0; n < NREQ; n++) begin
         resp_o[n]       = '0;
         resp_o[n].stall = req_i[n].cyc;
      end
      if (state_q == GRANT) begin
         resp_o[owner_q] = resp_i;
         if (fire) begin
            resp_o[owner_q].err = 1'b1;
         end
      end
      tmo_o = fire;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         wd_cnt_q <= '0;
         req_q    <= '0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         wd_cnt_q <= wd_cnt_d;
         req_q    <= req_d;
         gnt_q    <= gnt_d;
      end
   end

   assign req_o = req_q;
   assign gnt_o = gnt_q;

endmodule

// File: tb/tb_fta_arbiter32.sv
// Scenario bench for fta_arbiter32: expected owners/addresses queued at stimulus time,
// popped and compared when the shared port shows them.
module tb_fta_arbiter32;
   import fta_arbiter32_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   fta_cmd_request32_t  req    [4];
   fta_cmd_response32_t resp_o [4];
   fta_cmd_request32_t  req_o;
   fta_cmd_response32_t resp_s;
   logic [3:0]          gnt_o;
   logic                tmo_o;

   int errors = 0;
   int checks = 0;
   int          exp_owner [$];
   logic [31:0] exp_adr   [$];

   always #5 clk = ~clk;

   fta_arbiter32 #(.NREQ(4), .TIMEOUT(15)) dut (
      .rst_i  (rst),
      .clk_i  (clk),
      .req_i  (req),
      .resp_o (resp_o),
      .req_o  (req_o),
      .resp_i (resp_s),
      .gnt_o  (gnt_o),
      .tmo_o  (tmo_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt_o == 4'b0000 && n < 40);
   endtask

   task automatic pop_exp(output int o, output logic [31:0] a);
      o = -1;
      a = '0;
      if (exp_owner.size() > 0) o = exp_owner.pop_front();
      if (exp_adr.size() > 0)   a = exp_adr.pop_front();
   endtask

   task automatic test_reset();
      int bad;
      for (int n = 0; n < 4; n++) req[n] = '0;
      resp_s = '0;
      do_reset();
      checks++;
      if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
      checks++;
      if (req_o !== '0) begin errors++; $display("FAIL reset_req_o: got %h want 0", req_o); end
      checks++;
      if (tmo_o !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", tmo_o); end
      bad = 0;
      for (int n = 0; n < 4; n++) if (resp_o[n] !== '0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_resp: %0d nonzero, want 0", bad); end
      // Stray ack while idle must be discarded.
      resp_s.ack = 1'b1;
      #1;
      bad = 0;
      for (int n = 0; n < 4; n++) if (resp_o[n].ack !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_ack_drop: %0d acks forwarded, want 0", bad); end
      resp_s = '0;
   endtask

   task automatic test_single();
      int o; logic [31:0] a;
      req[1].cyc = 1'b1; req[1].sel = 4'hF; req[1].adr = 32'h1000;
      exp_owner.push_back(1); exp_adr.push_back(32'h1000);
      tick();
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o)) begin errors++; $display("FAIL single_gnt: got %b want %b", gnt_o, 4'(1 << o)); end
      checks++;
      if (req_o.adr !== a || req_o.cyc !== 1'b1)
         begin errors++; $display("FAIL single_adr: got adr %h cyc %b want %h 1", req_o.adr, req_o.cyc, a); end
      tick();
      tick();
      resp_s.ack = 1'b1; resp_s.dat = 32'hDEADBEEF;
      #1;
      checks++;
      if (resp_o[1].ack !== 1'b1 || resp_o[1].dat !== 32'hDEADBEEF)
         begin errors++; $display("FAIL single_ack: got ack %b dat %h want 1 deadbeef", resp_o[1].ack, resp_o[1].dat); end
      checks++;
      if (resp_o[0].ack !== 1'b0) begin errors++; $display("FAIL single_other_ack: got %b want 0", resp_o[0].ack); end
      tick();
      resp_s = '0; req[1].cyc = 1'b0;
      tick();
      checks++;
      if (gnt_o !== 4'b0000 || req_o.cyc !== 1'b0)
         begin errors++; $display("FAIL single_release: got gnt %b cyc %b want 0000 0", gnt_o, req_o.cyc); end
   endtask

   task automatic test_contention();
      int o, n, bad; logic [31:0] a;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         req[r].cyc = 1'b1; req[r].we = 1'b1; req[r].adr = 32'(r * 256);
         exp_owner.push_back(r); exp_adr.push_back(32'(r * 256));
      end
      for (int k = 0; k < 4; k++) begin
         wait_gnt(n);
         pop_exp(o, a);
         checks++;
         if (n != 1) begin errors++; $display("FAIL cont_latency%0d: got %0d cycles want 1", k, n); end
         checks++;
         if (gnt_o !== 4'(1 << o)) begin errors++; $display("FAIL cont_gnt%0d: got %b want %b", k, gnt_o, 4'(1 << o)); end
         checks++;
         if (req_o.adr !== a || req_o.we !== 1'b1)
            begin errors++; $display("FAIL cont_adr%0d: got %h we %b want %h 1", k, req_o.adr, req_o.we, a); end
         resp_s.ack = 1'b1;
         #1;
         bad = 0;
         for (int r = 0; r < 4; r++) begin
            if (r == o && resp_o[r].ack !== 1'b1) bad++;
            if (r != o && resp_o[r].ack !== 1'b0) bad++;
            if (r > o && resp_o[r].stall !== 1'b1) bad++;
         end
         checks++;
         if (bad != 0) begin errors++; $display("FAIL cont_steer%0d: %0d wrong resp fields want 0", k, bad); end
         tick();
         resp_s = '0;
         if (o >= 0) req[o].cyc = 1'b0;
         tick();
         checks++;
         if (gnt_o !== 4'b0000) begin errors++; $display("FAIL cont_idle%0d: got %b want 0000", k, gnt_o); end
      end
   endtask

   task automatic test_burst();
      int o, n; logic [31:0] a;
      req[2].cyc = 1'b1; req[2].adr = 32'h20; req[2].cti = 3'b010; req[2].blen = 6'd3; req[2].pri = 4'hA;
      exp_owner.push_back(2); exp_adr.push_back(32'h20);
      wait_gnt(n);
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o) || req_o.adr !== a)
         begin errors++; $display("FAIL burst_start: got gnt %b adr %h want %b %h", gnt_o, req_o.adr, 4'(1 << o), a); end
      checks++;
      if (req_o.blen !== 6'd3 || req_o.pri !== 4'hA)
         begin errors++; $display("FAIL burst_fields: got blen %0d pri %h want 3 a", req_o.blen, req_o.pri); end
      for (int b = 1; b < 4; b++) begin
         resp_s.ack = 1'b1;
         req[2].adr = 32'h20 + 32'(4 * b);
         req[2].cti = (b == 3) ? 3'b111 : 3'b010;
         exp_adr.push_back(req[2].adr);
         tick();
         a = exp_adr.pop_front();
         checks++;
         if (req_o.adr !== a || gnt_o !== 4'b0100)
            begin errors++; $display("FAIL burst_beat%0d: got adr %h gnt %b want %h 0100", b, req_o.adr, gnt_o, a); end
         checks++;
         if (req_o.cti !== ((b == 3) ? 3'b111 : 3'b010))
            begin errors++; $display("FAIL burst_cti%0d: got %b", b, req_o.cti); end
      end
      resp_s.ack = 1'b1;
      tick();
      resp_s = '0; req[2].cyc = 1'b0;
      tick();
      checks++;
      if (gnt_o !== 4'b0000) begin errors++; $display("FAIL burst_release: got %b want 0000", gnt_o); end
   endtask

   task automatic test_rr_wrap();
      int o, n; logic [31:0] a;
      req[0] = '0; req[3] = '0;
      req[0].cyc = 1'b1; req[0].adr = 32'h000;
      req[3].cyc = 1'b1; req[3].adr = 32'h300;
      exp_owner.push_back(3); exp_adr.push_back(32'h300);
      exp_owner.push_back(0); exp_adr.push_back(32'h000);
      for (int k = 0; k < 2; k++) begin
         wait_gnt(n);
         pop_exp(o, a);
         checks++;
         if (gnt_o !== 4'(1 << o) || req_o.adr !== a)
            begin errors++; $display("FAIL rr_wrap%0d: got gnt %b adr %h want %b %h", k, gnt_o, req_o.adr, 4'(1 << o), a); end
         if (o >= 0) req[o].cyc = 1'b0;
         tick();
      end
   endtask

   task automatic test_watchdog();
      int o, n, early; logic [31:0] a;
      req[0] = '0; req[1] = '0;
      req[0].cyc = 1'b1; req[0].adr = 32'h500;
      exp_owner.push_back(0); exp_adr.push_back(32'h500);
      wait_gnt(n);
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o)) begin errors++; $display("FAIL wd_gnt: got %b want %b", gnt_o, 4'(1 << o)); end
      req[1].cyc = 1'b1; req[1].adr = 32'h600;
      early = 0;
      for (int c = 1; c < 16; c++) begin
         #1;
         if (tmo_o !== 1'b0 || resp_o[0].err !== 1'b0 || req_o.cyc !== 1'b1 || resp_o[1].stall !== 1'b1) early++;
         tick();
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL wd_early: %0d bad cycles want 0", early); end
      checks++;
      if (tmo_o !== 1'b1 || resp_o[0].err !== 1'b1)
         begin errors++; $display("FAIL wd_fire: got tmo %b err %b want 1 1", tmo_o, resp_o[0].err); end
      tick();
      checks++;
      if (req_o.cyc !== 1'b0 || tmo_o !== 1'b0)
         begin errors++; $display("FAIL wd_cyc_drop: got cyc %b tmo %b want 0 0", req_o.cyc, tmo_o); end
      resp_s.ack = 1'b1;
      #1;
      checks++;
      if (resp_o[0].ack !== 1'b0 || resp_o[0].err !== 1'b0)
         begin errors++; $display("FAIL wd_late_ack: got ack %b err %b want 0 0", resp_o[0].ack, resp_o[0].err); end
      tick();
      resp_s = '0;
      tick();
      checks++;
      if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wd_hold: got %b want 0001", gnt_o); end
      req[0].cyc = 1'b0;
      exp_owner.push_back(1); exp_adr.push_back(32'h600);
      wait_gnt(n);
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o) || req_o.adr !== a || n != 2)
         begin errors++; $display("FAIL wd_next: got gnt %b adr %h after %0d want %b %h after 2", gnt_o, req_o.adr, n, 4'(1 << o), a); end
      req[1].cyc = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_burst();
      int o, n; logic [31:0] a;
      req[2] = '0;
      req[2].cyc = 1'b1; req[2].adr = 32'h40; req[2].cti = 3'b010; req[2].blen = 6'd3;
      exp_owner.push_back(2); exp_adr.push_back(32'h40);
      wait_gnt(n);
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o)) begin errors++; $display("FAIL rmb_gnt: got %b want %b", gnt_o, 4'(1 << o)); end
      resp_s.ack = 1'b1; req[2].adr = 32'h44;
      tick();
      resp_s = '0; rst = 1'b1;
      tick();
      checks++;
      if (req_o.cyc !== 1'b0 || gnt_o !== 4'b0000)
         begin errors++; $display("FAIL rmb_drop: got cyc %b gnt %b want 0 0000", req_o.cyc, gnt_o); end
      rst = 1'b0; req[2].cyc = 1'b0;
      req[1] = '0; req[3] = '0;
      req[1].cyc = 1'b1; req[1].adr = 32'h710;
      req[3].cyc = 1'b1; req[3].adr = 32'h730;
      exp_owner.push_back(1); exp_adr.push_back(32'h710);
      tick();
      pop_exp(o, a);
      checks++;
      if (gnt_o !== 4'(1 << o) || req_o.adr !== a)
         begin errors++; $display("FAIL rmb_regrant: got gnt %b adr %h want %b %h", gnt_o, req_o.adr, 4'(1 << o), a); end
      req[1].cyc = 1'b0; req[3].cyc = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      resp_s = '0;
      for (int n = 0; n < 4; n++) req[n] = '0;
      test_reset();
      test_single();
      test_contention();
      test_burst();
      test_rr_wrap();
      test_watchdog();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
